// File: rtl/cdc_toggle_handshake_tx.sv
// rtl/cdc_toggle_handshake_tx.sv - source-side toggle-handshake CDC launcher
// Holds one word on tx_data, flips req_toggle per word, waits for the synchronised ack level.
module cdc_toggle_handshake_tx #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] tx_data,
    output logic             req_toggle,
    input  logic             ack_toggle,
    output logic             busy,
    output logic             done,
    output logic             err_timeout,
    input  logic             err_clear
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {
        IDLE,
        WAIT_ACK
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic [CW-1:0]          tmo_cnt;
    logic                   ack_s;
    logic                   ack_match;
    logic                   accept;
    logic                   tmo_hit;

    assign ack_s     = ack_sync[SYNC_STAGES-1];
    assign ack_match = (ack_s == req_toggle);
    // A stale ack level after a one-sided reset keeps the launcher closed until levels agree.
    assign in_ready  = (state == IDLE) && ack_match;
    assign accept    = in_valid && in_ready;

    generate
        if (TIMEOUT > 0) begin : g_tmo
            assign tmo_hit = (state == WAIT_ACK) && (tmo_cnt == CW'(TIMEOUT - 1));
        end else begin : g_no_tmo
            assign tmo_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_toggle};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tx_data     <= '0;
            req_toggle  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            tmo_cnt     <= '0;
            err_timeout <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        tx_data    <= in_data;
                        req_toggle <= ~req_toggle;
                        state      <= WAIT_ACK;
                        busy       <= 1'b1;
                        tmo_cnt    <= '0;
                    end
                end
                WAIT_ACK: begin
                    if (tmo_cnt != CW'(TIMEOUT)) begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                    if (ack_match) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
            endcase
            // Set has priority over clear when both land on the same edge.
            if (tmo_hit) begin
                err_timeout <= 1'b1;
            end else if (err_clear) begin
                err_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cdc_toggle_handshake_tx.sv
// tb/tb_cdc_toggle_handshake_tx.sv - self-checking bench for cdc_toggle_handshake_tx
// Loopback receiver returns req_toggle as ack_toggle after LB_D clk cycles.
module tb_cdc_toggle_handshake_tx;

    localparam int WIDTH = 4;
    localparam int SYNC  = 2;
    localparam int TMO   = 8;
    localparam int LB_D  = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic [WIDTH-1:0] tx_data;
    logic             req_toggle;
    logic             ack_toggle;
    logic             busy;
    logic             done;
    logic             err_timeout;
    logic             err_clear = 1'b0;

    logic             lb_en = 1'b1;
    logic             ack_force = 1'b0;
    logic [LB_D-1:0]  lb = '0;

    int n_cmp = 0;
    int n_mis = 0;
    int done_cnt = 0;
    int req_edges = 0;
    logic req_prev = 1'b0;
    logic [WIDTH-1:0] rx_q[$];

    cdc_toggle_handshake_tx #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .tx_data(tx_data), .req_toggle(req_toggle),
        .ack_toggle(ack_toggle), .busy(busy), .done(done),
        .err_timeout(err_timeout), .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    always @(posedge clk) lb <= {lb[LB_D-2:0], req_toggle};
    assign ack_toggle = lb_en ? lb[LB_D-1] : ack_force;

    // Receiver model: captures the word whenever the request level changes.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (req_toggle !== req_prev) begin
            rx_q.push_back(tx_data);
            req_edges++;
        end
        req_prev = req_toggle;
    end

    task automatic wait_done(input int limit, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < limit && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if ({tx_data, req_toggle, busy, in_ready, done, err_timeout} !== {4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_mis++;
            $display("FAIL reset_state: got tx=%0h req=%0b busy=%0b rdy=%0b done=%0b err=%0b expected 0 0 0 1 0 0",
                     tx_data, req_toggle, busy, in_ready, done, err_timeout);
        end
    endtask

    task automatic test_single_word();
        int first = -1;
        int pulses = 0;
        logic rdy_at_done = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'hA;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 4'h0;
        n_cmp++;
        if ({req_toggle, tx_data, busy} !== {1'b1, 4'hA, 1'b1}) begin
            n_mis++;
            $display("FAIL single_launch: got req=%0b tx=%0h busy=%0b expected 1 a 1", req_toggle, tx_data, busy);
        end
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (done) begin
                pulses++;
                if (first < 0) begin
                    first = k;
                    rdy_at_done = in_ready;
                end
            end
        end
        n_cmp++;
        if (first != SYNC + 1 + LB_D) begin
            n_mis++;
            $display("FAIL single_latency: got %0d expected %0d", first, SYNC + 1 + LB_D);
        end
        n_cmp++;
        if (pulses != 1) begin
            n_mis++;
            $display("FAIL single_done_count: got %0d expected 1", pulses);
        end
        n_cmp++;
        if (rdy_at_done !== 1'b1 || tx_data !== 4'hA) begin
            n_mis++;
            $display("FAIL single_ready_hold: got rdy=%0b tx=%0h expected 1 a", rdy_at_done, tx_data);
        end
    endtask

    task automatic test_stream();
        int n = 0;
        int guard = 0;
        int d0 = done_cnt;
        int e0 = req_edges;
        logic acc;
        rx_q.delete();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = '0;
        while (n < 16 && guard < 400) begin
            acc = in_ready;
            @(negedge clk);
            guard++;
            if (acc) begin
                n++;
                in_data = WIDTH'(n);
            end
            if (n == 16) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
        n_cmp++;
        if (rx_q.size() != 16) begin
            n_mis++;
            $display("FAIL stream_rx_count: got %0d expected 16", rx_q.size());
        end
        for (int i = 0; i < 16 && i < rx_q.size(); i++) begin
            n_cmp++;
            if (rx_q[i] !== WIDTH'(i)) begin
                n_mis++;
                $display("FAIL stream_word_%0d: got %0h expected %0h", i, rx_q[i], i);
            end
        end
        n_cmp++;
        if (done_cnt - d0 != 16 || req_edges - e0 != 16) begin
            n_mis++;
            $display("FAIL stream_pulses: got done=%0d edges=%0d expected 16 16", done_cnt - d0, req_edges - e0);
        end
    endtask

    task automatic test_backpressure();
        int e0 = req_edges;
        bit seen;
        logic req_exp;
        rx_q.delete();
        @(negedge clk);
        req_exp  = ~req_toggle;
        in_valid = 1'b1;
        in_data  = 4'h3;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'h5;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if ({tx_data, req_toggle, busy} !== {4'h3, req_exp, 1'b1}) begin
            n_mis++;
            $display("FAIL backpressure_hold: got tx=%0h req=%0b busy=%0b expected 3 %0b 1", tx_data, req_toggle, busy, req_exp);
        end
        wait_done(20, seen);
        repeat (4) @(negedge clk);
        n_cmp++;
        if (!seen || req_edges - e0 != 1 || rx_q.size() != 1) begin
            n_mis++;
            $display("FAIL backpressure_words: got done=%0b edges=%0d expected 1 1", seen, req_edges - e0);
        end
    endtask

    task automatic test_random();
        int next_free = 0;
        int d0 = done_cnt;
        int rdy_bad = 0;
        logic [WIDTH-1:0] exp_q[$];
        rx_q.delete();
        for (int cyc = 0; cyc < 300; cyc++) begin
            @(negedge clk);
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = WIDTH'($urandom);
            #1;
            n_cmp++;
            if (in_ready !== (cyc >= next_free)) begin
                n_mis++;
                rdy_bad++;
                if (rdy_bad < 5)
                    $display("FAIL random_ready c%0d: got %0b expected %0b", cyc, in_ready, cyc >= next_free);
            end
            if (in_valid && cyc >= next_free) begin
                exp_q.push_back(in_data);
                next_free = cyc + SYNC + 2 + LB_D;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (12) @(negedge clk);
        n_cmp++;
        if (rx_q.size() != exp_q.size() || done_cnt - d0 != exp_q.size()) begin
            n_mis++;
            $display("FAIL random_count: got rx=%0d done=%0d expected %0d", rx_q.size(), done_cnt - d0, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_cmp++;
            if (rx_q[i] !== exp_q[i]) begin
                n_mis++;
                $display("FAIL random_word_%0d: got %0h expected %0h", i, rx_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_timeout();
        bit seen;
        logic [WIDTH-1:0] d;
        @(negedge clk);
        ack_force = req_toggle;
        lb_en     = 1'b0;
        in_valid  = 1'b1;
        d         = WIDTH'($urandom);
        in_data   = d;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (TMO - 1) @(negedge clk);
        n_cmp++;
        if (err_timeout !== 1'b0) begin
            n_mis++;
            $display("FAIL timeout_early: got %0b expected 0", err_timeout);
        end
        @(negedge clk);
        n_cmp++;
        if ({err_timeout, busy} !== 2'b11) begin
            n_mis++;
            $display("FAIL timeout_set: got err=%0b busy=%0b expected 1 1", err_timeout, busy);
        end
        repeat (5) @(negedge clk);
        ack_force = ~ack_force;
        wait_done(10, seen);
        n_cmp++;
        if (!seen || err_timeout !== 1'b1 || tx_data !== d) begin
            n_mis++;
            $display("FAIL timeout_late_ack: got done=%0b err=%0b tx=%0h expected 1 1 %0h", seen, err_timeout, tx_data, d);
        end
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        n_cmp++;
        if (err_timeout !== 1'b0) begin
            n_mis++;
            $display("FAIL timeout_clear: got %0b expected 0", err_timeout);
        end
        in_valid = 1'b1;
        in_data  = WIDTH'($urandom);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (TMO - 1) @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        n_cmp++;
        if (err_timeout !== 1'b1) begin
            n_mis++;
            $display("FAIL timeout_set_wins: got %0b expected 1", err_timeout);
        end
        ack_force = ~ack_force;
        wait_done(10, seen);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        n_cmp++;
        if (!seen || err_timeout !== 1'b0) begin
            n_mis++;
            $display("FAIL timeout_second: got done=%0b err=%0b expected 1 0", seen, err_timeout);
        end
        lb_en = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'h9;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({tx_data, req_toggle, busy, done, err_timeout} !== 8'h00) begin
            n_mis++;
            $display("FAIL async_reset: got tx=%0h req=%0b busy=%0b done=%0b err=%0b expected all 0",
                     tx_data, req_toggle, busy, done, err_timeout);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset_mismatch();
        int d0;
        int e0;
        @(negedge clk);
        lb_en     = 1'b0;
        ack_force = 1'b1;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (SYNC + 1) @(negedge clk);
        d0 = done_cnt;
        e0 = req_edges;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_mis++;
            $display("FAIL mismatch_blocked: got %0b expected 0", in_ready);
        end
        in_valid = 1'b1;
        in_data  = 4'h7;
        repeat (5) @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (done_cnt != d0 || req_edges != e0 || req_toggle !== 1'b0) begin
            n_mis++;
            $display("FAIL mismatch_no_issue: got done=%0d edges=%0d req=%0b expected 0 0 0",
                     done_cnt - d0, req_edges - e0, req_toggle);
        end
        ack_force = 1'b0;
        repeat (SYNC - 1) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_mis++;
            $display("FAIL mismatch_early_ready: got %0b expected 0", in_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL mismatch_release: got %0b expected 1", in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_stream();
        test_backpressure();
        test_random();
        test_timeout();
        test_async_reset();
        test_reset_mismatch();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
